// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller: FSM state encoding,
// timer width and the floor-index width helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOOR = 2'd1,
    MOVE = 2'd2
  } state_e;

  localparam int TICK_W = 8;

  // Floor index width: clog2(n), never narrower than one bit.
  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Loadable down-counter advanced by the tick timebase; holds at zero.
// A load always takes precedence over a tick.
module elev_tick_timer
  import elevator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  input  logic              tick,
  output logic [TICK_W-1:0] count,
  output logic              done
);

  logic [TICK_W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: IDLE/DOOR/MOVE FSM with latched calls and
// tick-based travel/door timers. Optional homing via ELEVATOR_IDLE_HOME_EN.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int TRAVEL_TICKS = 10,
  parameter int DOOR_TICKS   = 10,
  parameter int HOME_TICKS   = 30
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tick,
  input  logic [NUM_FLOORS-1:0]              call_req,
  output logic [floor_w(NUM_FLOORS)-1:0]     cur_floor,
  output logic                               dir_up,
  output logic                               moving,
  output logic                               door_open,
  output logic [NUM_FLOORS-1:0]              pending,
  output logic                               arrive
);

  localparam int FLOOR_W = floor_w(NUM_FLOORS);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
  logic                    dir_up_q, dir_up_d;
  logic                    moving_q, door_open_q;
  logic                    arrive_q, arrive_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   cur_mask;
  logic                    any_above, any_below;
  logic                    travel_load, door_load;
  logic [TICK_W-1:0]       travel_cnt, door_cnt;
  logic                    travel_done, door_done;
  logic                    travel_expire, door_expire;
  logic                    home_set;

  elev_tick_timer u_travel_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (travel_load),
    .load_val (TICK_W'(TRAVEL_TICKS)),
    .tick     (tick),
    .count    (travel_cnt),
    .done     (travel_done)
  );

  elev_tick_timer u_door_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (door_load),
    .load_val (TICK_W'(DOOR_TICKS)),
    .tick     (tick),
    .count    (door_cnt),
    .done     (door_done)
  );

  // Expire on the tick that takes the count from 1 to 0; a zero count exits at once.
  assign travel_expire = travel_done || (tick && travel_cnt == TICK_W'(1));
  assign door_expire   = door_done   || (tick && door_cnt   == TICK_W'(1));

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && i > int'(cur_floor_q)) any_above = 1'b1;
      if (pending_q[i] && i < int'(cur_floor_q)) any_below = 1'b1;
    end
  end

`ifdef ELEVATOR_IDLE_HOME_EN
  logic [TICK_W-1:0] home_q, home_d;

  // Only an undisturbed, empty IDLE away from floor 0 accumulates ticks.
  always_comb begin
    home_d   = '0;
    home_set = 1'b0;
    if (state_q == IDLE && pending_q == '0 && call_req == '0 && cur_floor_q != '0) begin
      home_d = home_q;
      if (tick) begin
        if (int'(home_q) + 1 >= HOME_TICKS) begin
          home_set = 1'b1;
          home_d   = '0;
        end else begin
          home_d = home_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) home_q <= '0;
    else       home_q <= home_d;
  end
`else
  logic unused_home_ticks;
  assign unused_home_ticks = ^HOME_TICKS;
  assign home_set          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    arrive_d    = 1'b0;
    travel_load = 1'b0;
    door_load   = 1'b0;
    cur_mask    = '0;
    cur_mask[cur_floor_q] = 1'b1;

    // At rest, the current floor is served by the door rather than latched.
    if (state_q == MOVE) pending_d = pending_q | call_req;
    else                 pending_d = (pending_q | call_req) & ~cur_mask;
    pending_d = pending_d | NUM_FLOORS'(home_set);

    unique case (state_q)
      IDLE: begin
        if (pending_q[cur_floor_q] || call_req[cur_floor_q]) begin
          state_d   = DOOR;
          door_load = 1'b1;
        end else if (dir_up_q ? any_above : any_below) begin
          state_d     = MOVE;
          travel_load = 1'b1;
        end else if (dir_up_q ? any_below : any_above) begin
          dir_up_d    = ~dir_up_q;
          state_d     = MOVE;
          travel_load = 1'b1;
        end
      end
      DOOR: begin
        if (call_req[cur_floor_q]) begin
          door_load = 1'b1;
        end else if (door_expire) begin
          state_d = IDLE;
        end
      end
      MOVE: begin
        if (travel_expire) begin
          state_d  = IDLE;
          arrive_d = 1'b1;
          if (dir_up_q && int'(cur_floor_q) < NUM_FLOORS - 1) begin
            cur_floor_d = cur_floor_q + 1'b1;
          end else if (!dir_up_q && cur_floor_q != '0) begin
            cur_floor_d = cur_floor_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      arrive_q    <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= (state_d == MOVE);
      door_open_q <= (state_d == DOOR);
      arrive_q    <= arrive_d;
      pending_q   <= pending_d;
    end
  end

  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign arrive    = arrive_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: expected arrival and door-open floors are
// queued with each call and popped by a monitor when the car produces them.
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] call_req;
  logic [1:0] cur_floor;
  logic       dir_up, moving, door_open, arrive;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;
  int arr_q[$];
  int door_q[$];
  logic door_prev = 1'b0;

  elevator_ctrl #(
    .NUM_FLOORS  (4),
    .TRAVEL_TICKS(10),
    .DOOR_TICKS  (10),
    .HOME_TICKS  (30)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .call_req (call_req),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open),
    .pending  (pending),
    .arrive   (arrive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: arrivals and door openings must match the queued floors.
  always @(negedge clk) begin
    if (!reset) begin
      if (arrive) begin
        int exp_f;
        exp_f = (arr_q.size() != 0) ? arr_q.pop_front() : -1;
        check("arrive floor", 32'(cur_floor), 32'(exp_f));
      end
      if (door_open && !door_prev) begin
        int exp_f;
        exp_f = (door_q.size() != 0) ? door_q.pop_front() : -1;
        check("door floor", 32'(cur_floor), 32'(exp_f));
      end
      if (door_open && moving) check("door/move exclusive", 32'(door_open & moving), 32'd0);
    end
    door_prev = door_open;
  end

  task automatic tick_once();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_call(input logic [3:0] mask);
    call_req = mask;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic ticks_while_moving(output int n);
    n = 0;
    while (moving && n < 200) begin
      tick_once();
      n++;
    end
  endtask

  task automatic ticks_while_door(output int n);
    n = 0;
    while (door_open && n < 200) begin
      tick_once();
      n++;
    end
  endtask

  task automatic run_until_quiet(input string tag);
    int guard;
    guard = 0;
    while ((moving || door_open || pending != '0) && guard < 400) begin
      if (moving || door_open) tick_once();
      else @(negedge clk);
      guard++;
    end
    check({tag, " settles"}, 32'(guard < 400), 32'd1);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    tick     = 1'b0;
    call_req = '0;
    repeat (2) @(negedge clk);
    check("reset cur_floor", 32'(cur_floor), 32'd0);
    check("reset dir_up",    32'(dir_up),    32'd1);
    check("reset moving",    32'(moving),    32'd0);
    check("reset door_open", 32'(door_open), 32'd0);
    check("reset pending",   32'(pending),   32'd0);
    check("reset arrive",    32'(arrive),    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Floor 0 -> 3, one floor per 10 ticks, then a 10-tick door.
    arr_q.push_back(1); arr_q.push_back(2); arr_q.push_back(3);
    door_q.push_back(3);
    pulse_call(4'b1000);
    check("s1 latched", 32'(pending), 32'b1000);
    @(negedge clk);
    check("s1 moving", 32'(moving), 32'd1);
    ticks_while_moving(n);
    check("s1 travel ticks", 32'(n), 32'd30);
    check("s1 door open", 32'(door_open), 32'd1);
    ticks_while_door(n);
    check("s1 door ticks", 32'(n), 32'd10);
    check("s1 pending", 32'(pending), 32'd0);
    check("s1 floor", 32'(cur_floor), 32'd3);

    // At floor 3 heading up, calls below reverse the direction.
    check("s2 dir before", 32'(dir_up), 32'd1);
    arr_q.push_back(2); arr_q.push_back(1); arr_q.push_back(0);
    door_q.push_back(1); door_q.push_back(0);
    pulse_call(4'b0011);
    @(negedge clk);
    check("s2 dir toggled", 32'(dir_up), 32'd0);
    check("s2 moving", 32'(moving), 32'd1);
    run_until_quiet("s2");
    check("s2 floor", 32'(cur_floor), 32'd0);

    // Door at floor 2 with 3 ticks left; a same-floor call reloads it.
    arr_q.push_back(1); arr_q.push_back(2);
    door_q.push_back(2);
    pulse_call(4'b0100);
    @(negedge clk);
    ticks_while_moving(n);
    check("s3 travel ticks", 32'(n), 32'd20);
    repeat (7) tick_once();
    check("s3 door still open", 32'(door_open), 32'd1);
    pulse_call(4'b0100);
    check("s3 not latched", 32'(pending), 32'd0);
    check("s3 door open", 32'(door_open), 32'd1);
    ticks_while_door(n);
    check("s3 reloaded door ticks", 32'(n), 32'd10);
    check("s3 pending", 32'(pending), 32'd0);

    // Position at floor 1 travelling up, then call floors 3 and 0.
    arr_q.push_back(1); arr_q.push_back(0);
    door_q.push_back(0);
    pulse_call(4'b0001);
    run_until_quiet("s4a");
    arr_q.push_back(1);
    door_q.push_back(1);
    pulse_call(4'b0010);
    run_until_quiet("s4b");
    check("s4 at floor 1", 32'(cur_floor), 32'd1);
    check("s4 dir up", 32'(dir_up), 32'd1);
    arr_q.push_back(2); arr_q.push_back(3); arr_q.push_back(2);
    arr_q.push_back(1); arr_q.push_back(0);
    door_q.push_back(3); door_q.push_back(0);
    pulse_call(4'b1001);
    run_until_quiet("s4c");
    check("s4 final floor", 32'(cur_floor), 32'd0);

    // Reset mid-MOVE, with a call presented during the reset cycle.
    arr_q.push_back(1);
    pulse_call(4'b1000);
    @(negedge clk);
    repeat (15) tick_once();
    check("s5 floor before reset", 32'(cur_floor), 32'd1);
    check("s5 moving before reset", 32'(moving), 32'd1);
    reset    = 1'b1;
    call_req = 4'b0010;
    @(negedge clk);
    reset    = 1'b0;
    call_req = '0;
    check("s5 cur_floor", 32'(cur_floor), 32'd0);
    check("s5 moving", 32'(moving), 32'd0);
    check("s5 pending", 32'(pending), 32'd0);
    check("s5 dir_up", 32'(dir_up), 32'd1);
    @(negedge clk);
    check("s5 stays idle", 32'(moving | door_open), 32'd0);

    // Idle at floor 2: homing after 30 ticks only when compiled in.
    arr_q.push_back(1); arr_q.push_back(2);
    door_q.push_back(2);
    pulse_call(4'b0100);
    run_until_quiet("s6a");
    repeat (29) tick_once();
    check("s6 no home yet", 32'(pending), 32'd0);
`ifdef ELEVATOR_IDLE_HOME_EN
    arr_q.push_back(1); arr_q.push_back(0);
    door_q.push_back(0);
    tick_once();
    check("s6 home requested", 32'(pending), 32'b0001);
    run_until_quiet("s6b");
    check("s6 homed", 32'(cur_floor), 32'd0);
`else
    tick_once();
    check("s6 no home request", 32'(pending), 32'd0);
    repeat (20) tick_once();
    check("s6 parked floor", 32'(cur_floor), 32'd2);
    check("s6 parked", 32'(moving), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("arrivals drained", 32'(arr_q.size()), 32'd0);
    check("doors drained", 32'(door_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 4: number of served floors, legal range 2..16.
REQ-002 SHALL have parameter TRAVEL_TICKS, default 10: tick pulses needed to travel one floor, legal range 1..255.
REQ-003 SHALL have parameter DOOR_TICKS, default 10: tick pulses the door stays open, legal range 1..255.
REQ-004 SHALL have parameter HOME_TICKS, default 30: idle tick pulses before homing; used only under REQ-023.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle timebase enable (nominally 1 Hz).
REQ-008 SHALL have port call_req, input, NUM_FLOORS bits: one-cycle call pulses, one bit per floor (hall and car calls merged).
REQ-009 SHALL have port cur_floor, output, FLOOR_W = clog2(NUM_FLOORS) bits: last floor reached.
REQ-010 SHALL have port dir_up, output, 1 bit: current or last travel direction, 1 = up.
REQ-011 SHALL have port moving, output, 1 bit: high while in MOVE.
REQ-012 SHALL have port door_open, output, 1 bit: high while in DOOR.
REQ-013 SHALL have port pending, output, NUM_FLOORS bits: latched unserved calls.
REQ-014 SHALL have port arrive, output, 1 bit: one-cycle pulse in the cycle cur_floor changes.

Function
REQ-015 SHALL implement states IDLE, DOOR and MOVE, with all outputs registered.
REQ-016 Latching SHALL follow pending_next = (pending & ~served) | call_req.
- A call for cur_floor while in IDLE or DOOR is not latched.
- In IDLE it opens the door (IDLE->DOOR next cycle).
- In DOOR it reloads the door timer to DOOR_TICKS.
- If a call and a clear for the same bit occur in the same cycle, the set wins, except for cur_floor as above.
REQ-017 IDLE SHALL apply the following priority, evaluated each cycle:
- pending[cur_floor]: clear the bit, go to DOOR.
- Else any pending bit in dir_up's direction: go to MOVE with dir_up kept.
- Else any pending bit in the opposite direction: toggle dir_up, go to MOVE.
- Else stay in IDLE.
REQ-018 MOVE SHALL load the travel timer with TRAVEL_TICKS on entry and decrement it on each tick. On the tick where it reaches 0, it SHALL:
- step cur_floor by ±1;
- pulse arrive;
- return to IDLE.
Net latency from the last travel tick to door_open = 2 cycles when the new floor is pending.
REQ-019 DOOR SHALL load the door timer with DOOR_TICKS and decrement it on each tick; at 0, go to IDLE with door_open low.
REQ-020 cur_floor SHALL never leave 0..NUM_FLOORS-1; direction selection guarantees this, and no wrap-around is permitted.
REQ-021 door_open and moving SHALL never be high in the same cycle.
REQ-022 Without tick pulses, timers SHALL hold and the state SHALL not advance, except the IDLE decisions, which are tick-independent.

Configuration
REQ-023 Homing SHALL be compiled in by macro ELEVATOR_IDLE_HOME_EN.
- When defined: in IDLE with pending == 0 and cur_floor != 0, the home counter counts ticks. Reaching HOME_TICKS sets pending[0]. Any call or state change clears the counter.
- When undefined: the car parks indefinitely, the home counter is absent, and HOME_TICKS is ignored.

Reset
REQ-024 Reset, synchronous and active-high, SHALL force state IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0, arrive=0, and all timers/counters to 0. This applies mid-MOVE and mid-DOOR, and call_req is ignored during the reset cycle.

Structure
REQ-025 Package elevator_pkg SHALL hold:
- the state enum {IDLE, DOOR, MOVE};
- the tick counter width constant TICK_W = 8;
- a floor-width function returning clog2(n), min 1.
REQ-026 Sub-module elev_tick_timer SHALL be used for both timers. It is a loadable TICK_W-bit down-counter with load, tick and done ports; done is combinational at count 0.
REQ-027 Direction search (any pending above/below cur_floor) SHALL be combinational masking within elevator_ctrl.

Verification
REQ-028 The bench SHALL cover: reset, then call_req=4'b1000, TRAVEL_TICKS=10 -> moving for 30 ticks, arrive pulses at floors 1, 2, 3, door_open for 10 ticks, pending=0.
REQ-029 The bench SHALL cover: at floor 3, dir_up=1, calls at floors 0 and 1 -> dir_up toggles to 0, stops at 1 then 0, door opens at each floor.
REQ-030 The bench SHALL cover: at floor 2 in DOOR with 3 ticks left, call_req=4'b0100 -> timer reloads, door_open lasts 10 more ticks, pending[2] stays 0.
REQ-031 The bench SHALL cover: at floor 1 going up with calls at floors 3 and 0 -> serves floor 3 first, then floor 0.
REQ-032 The bench SHALL cover: reset asserted mid-MOVE at tick 5 -> next cycle cur_floor=0, moving=0, pending=0.
REQ-033 The bench SHALL cover, with ELEVATOR_IDLE_HOME_EN and HOME_TICKS=30: idle at floor 2 -> pending[0] set after 30 ticks, car returns to 0; without the macro, the car stays at floor 2.
